weight_kernel_loader: RTL

- Double-buffered weight loader/sequencer for the weight-stationary conv datapath.
- Accepts one kernel as a row-major stream of signed weights over a valid/ready handshake and assembles it in a shadow buffer.
- Commits the shadow buffer to the active kernel register only while the array reports idle.
- Drives the same packed weight bus the conv array consumes, so the array sees a full kernel swap atomically; the next kernel can stream in while the current one is in use.

---
 rtl/weight_stationary_pkg.sv | 20 ++
 rtl/weight_kernel_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/weight_stationary_pkg.sv
// Shared definitions for the weight-stationary conv datapath.
//   loader_state_e  : weight loader FSM states (LOAD, FULL)
//   DEFAULT_*       : default kernel geometry and weight width
//   kernel_words()  : number of weights in an h x w kernel
package weight_stationary_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } loader_state_e;

    localparam int DEFAULT_KERNEL_WIDTH  = 3;
    localparam int DEFAULT_KERNEL_HEIGHT = 3;
    localparam int DEFAULT_WEIGHT_WIDTH  = 8;

    function automatic int kernel_words(input int h, input int w);
        return h * w;
    endfunction

endpackage

// File: rtl/weight_kernel_loader.sv
// Double-buffered weight loader for the weight-stationary conv array.
// A kernel arrives as a row-major stream of signed weights and is assembled
// in a shadow buffer; the whole kernel is copied to the active register in a
// single cycle while the array is idle, so the array never sees a mix of two
// kernels. The next kernel may stream in while the current one is in use.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   w_valid_i/w_ready_o/w_data_i/w_last_i
//                    weight stream; w_last_i marks the final word of a kernel
//   array_busy_i     array is using the active kernel; commit is held off
//   err_clr_i        clears the sticky framing error
//   weight_o         active kernel, element [r][c]
//   weight_valid_o   weight_o holds a committed kernel
//   swap_o           one-cycle pulse in the cycle weight_o takes a new kernel
//   err_o            sticky framing error (early or missing last)
module weight_kernel_loader
    import weight_stationary_pkg::*;
#(
    parameter int KERNEL_WIDTH  = DEFAULT_KERNEL_WIDTH,
    parameter int KERNEL_HEIGHT = DEFAULT_KERNEL_HEIGHT,
    parameter int WEIGHT_WIDTH  = DEFAULT_WEIGHT_WIDTH
) (
    input  logic                                                                 clk_i,
    input  logic                                                                 rst_ni,
    input  logic                                                                 w_valid_i,
    input  logic signed [WEIGHT_WIDTH-1:0]                                       w_data_i,
    input  logic                                                                 w_last_i,
    output logic                                                                 w_ready_o,
    input  logic                                                                 array_busy_i,
    input  logic                                                                 err_clr_i,
    output logic signed [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][WEIGHT_WIDTH-1:0] weight_o,
    output logic                                                                 weight_valid_o,
    output logic                                                                 swap_o,
    output logic                                                                 err_o
);

    localparam int N     = kernel_words(KERNEL_HEIGHT, KERNEL_WIDTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int ROW_W = (KERNEL_HEIGHT > 1) ? $clog2(KERNEL_HEIGHT) : 1;
    localparam int COL_W = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(KERNEL_WIDTH - 1);

    typedef logic signed [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][WEIGHT_WIDTH-1:0] kernel_t;

    loader_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    kernel_t          shadow_q;

    logic handshake;
    logic last_word;
    logic kernel_done;
    logic frame_err;
    logic commit;

    // The linear index only decides framing; row/column address the shadow
    // buffer directly, so no divide or modulo is needed.
    assign handshake   = w_valid_i && (state_q == LOAD);
    assign last_word   = (idx_q == IDX_LAST);
    assign kernel_done = handshake && last_word && w_last_i;
    // Early last and missing last both show up as last_word != w_last_i.
    assign frame_err   = handshake && (last_word != w_last_i);
    // array_busy_i is only looked at while a kernel is pending.
    assign commit      = (state_q == FULL) && !array_busy_i;

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        w_ready_o = 1'b0;
        case (state_q)
            LOAD: begin
                w_ready_o = 1'b1;
                if (kernel_done) state_d = FULL;
            end
            FULL: begin
                if (!array_busy_i) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Word position. Any word carrying last, or the N-th word, ends the frame
    // (good or bad) and restarts at [0][0].
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else if (handshake) begin
            if (last_word || w_last_i) begin
                idx_q <= '0;
                row_q <= '0;
                col_q <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // NOTE: the shadow buffer is cleared on reset on purpose, so that a reset
    // mid-load leaves no stale weights behind; storage without that need
    // would normally be left unreset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else if (handshake) begin
            shadow_q[row_q][col_q] <= w_data_i;
        end
    end

    // Active kernel: changes only on a commit, as one whole-kernel copy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            weight_o       <= '0;
            weight_valid_o <= 1'b0;
            swap_o         <= 1'b0;
        end else begin
            swap_o <= commit;
            if (commit) begin
                weight_o       <= shadow_q;
                weight_valid_o <= 1'b1;
            end
        end
    end

    // Sticky error; a new error on the same edge as a clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (frame_err) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

endmodule
